// File: rtl/reg_wr_arb.sv
// Write-port arbiter for the general register file: picks core or debug, holds the
// write and drives the single write port until the T3 strobe commits it.
// Optional build macro REGARB_ZERO_GUARD_EN suppresses the write enable for register 0.
module reg_wr_arb #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              t3,
    input  logic              core_valid,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_data,
    output logic              core_ready,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              busy_q, busy_d;

    logic              dbg_win_s;
    logic              core_win_s;
    logic              core_acc_s;
    logic              dbg_acc_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_we_s;

    // Winner selection and accept pulses; debug wins only once core has starved it long enough.
    always_comb begin
        dbg_win_s  = dbg_valid && !(core_valid && (starve_cnt_q != STARVE_LIM));
        core_win_s = core_valid && !dbg_win_s;
        core_acc_s = resetn && (state_q == IDLE) && core_win_s;
        dbg_acc_s  = resetn && (state_q == IDLE) && dbg_win_s;
        if (dbg_win_s) begin
            sel_addr_s = dbg_addr;
            sel_data_s = dbg_data;
        end else begin
            sel_addr_s = core_addr;
            sel_data_s = core_data;
        end
`ifdef REGARB_ZERO_GUARD_EN
        sel_we_s = (sel_addr_s != {ADDR_W{1'b0}});
`else
        sel_we_s = 1'b1;
`endif
    end

    // Next-state logic for the FSM, the hold registers and the starvation counter.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        rf_we_d      = rf_we_q;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (core_acc_s || dbg_acc_s) begin
                    state_d    = HOLD;
                    busy_d     = 1'b1;
                    rf_we_d    = sel_we_s;
                    rf_waddr_d = sel_addr_s;
                    rf_wdata_d = sel_data_s;
                    if (dbg_win_s) begin
                        starve_cnt_d = 4'd0;
                    end else if (dbg_valid && (starve_cnt_q != STARVE_LIM)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                // t3 here is the commit edge; address/data stay latched afterwards.
                if (t3) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    rf_we_d = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rf_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= {ADDR_W{1'b0}};
            rf_wdata_q   <= {DATA_W{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign core_ready = core_acc_s;
    assign dbg_ready  = dbg_acc_s;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_reg_wr_arb.sv
// Scoreboard bench for reg_wr_arb: directed stimulus pushes expected accepts and
// commits into queues; a negedge monitor pops and compares them.
module tb_reg_wr_arb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          t3;
    logic          core_valid;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_data;
    logic          core_ready;
    logic          dbg_valid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          dbg_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    int            acc_q[$];   // 0 = core, 1 = debug
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];

    reg_wr_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .resetn(resetn), .t3(t3),
        .core_valid(core_valid), .core_addr(core_addr), .core_data(core_data),
        .core_ready(core_ready),
        .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .dbg_ready(dbg_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for an accept pulse, return 1 ns into the following cycle.
    task automatic wait_accept();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (core_ready || dbg_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_timeout", 64'(got), 64'd1);
        step();
    endtask

    task automatic push_write(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit commits);
        acc_q.push_back(who);
        if (commits) begin
            wa_q.push_back(a);
            wd_q.push_back(d);
        end
    endtask

    // Monitor: every accept pulse and every register-file commit is checked against the queues.
    always @(negedge clk) begin
        if (core_ready || dbg_ready) begin
            if (acc_q.size() == 0) begin
                check("unexpected_accept", {62'd0, core_ready, dbg_ready}, 64'd0);
            end else begin
                int e;
                e = acc_q.pop_front();
                check("accept_winner", {62'd0, core_ready, dbg_ready}, (e == 1) ? 64'd1 : 64'd2);
            end
        end
        if (t3 && rf_we) begin
            if (wa_q.size() == 0) begin
                check("unexpected_commit", 64'(rf_we), 64'd0);
            end else begin
                logic [AW-1:0] ea;
                logic [DW-1:0] ed;
                ea = wa_q.pop_front();
                ed = wd_q.pop_front();
                check("commit_addr", 64'(rf_waddr), 64'(ea));
                check("commit_data", 64'(rf_wdata), 64'(ed));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    int            ck;
    int            win_tbl[6] = '{0, 0, 0, 0, 1, 0};

    initial begin
        resetn     = 1'b0;
        t3         = 1'b0;
        core_valid = 1'b1;
        core_addr  = 5'd7;
        core_data  = 32'h0000_0011;
        dbg_valid  = 1'b0;
        dbg_addr   = 5'd0;
        dbg_data   = 32'd0;

        // Reset with a pending core request: everything quiet while resetn=0.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_core_ready", 64'(core_ready), 64'd0);
            check("rst_dbg_ready", 64'(dbg_ready), 64'd0);
            check("rst_rf_we", 64'(rf_we), 64'd0);
            check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
            check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
        end
        step();
        resetn = 1'b1;
        push_write(0, 5'd7, 32'h0000_0011, 1'b1);
        @(negedge clk);
        check("ready_after_reset", 64'(core_ready), 64'd1);
        step();
        core_valid = 1'b0;
        t3 = 1'b1;
        step();
        t3 = 1'b0;

        // Single core write, t3 two cycles after accept.
        core_valid = 1'b1;
        core_addr  = 5'd3;
        core_data  = 32'hDEAD_BEEF;
        push_write(0, 5'd3, 32'hDEAD_BEEF, 1'b1);
        wait_accept();
        core_valid = 1'b0;
        @(negedge clk);
        check("hold_we", 64'(rf_we), 64'd1);
        check("hold_waddr", 64'(rf_waddr), 64'd3);
        check("hold_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        check("hold_busy", 64'(busy), 64'd1);
        step();
        t3 = 1'b1;
        @(negedge clk);
        check("hold_we_t3", 64'(rf_we), 64'd1);
        step();
        t3 = 1'b0;
        @(negedge clk);
        check("post_commit_we", 64'(rf_we), 64'd0);
        check("post_commit_busy", 64'(busy), 64'd0);

        // t3 coinciding with the accept cycle must not commit.
        step();
        core_valid = 1'b1;
        core_addr  = 5'd5;
        core_data  = 32'h5555_AAAA;
        t3 = 1'b1;
        push_write(0, 5'd5, 32'h5555_AAAA, 1'b1);
        wait_accept();
        core_valid = 1'b0;
        t3 = 1'b0;
        @(negedge clk);
        check("t3acc_busy1", 64'(busy), 64'd1);
        step();
        @(negedge clk);
        check("t3acc_busy2", 64'(busy), 64'd1);
        check("t3acc_we2", 64'(rf_we), 64'd1);
        step();
        t3 = 1'b1;
        step();
        t3 = 1'b0;
        @(negedge clk);
        check("t3acc_done", 64'(busy), 64'd0);

        // Contention: core wins 4, debug the 5th, core the 6th.
        step();
        ck = 1;
        ca = 5'(10 + ck);
        cd = 32'hC000_0000 + 32'(ck);
        core_valid = 1'b1;
        core_addr  = ca;
        core_data  = cd;
        dbg_valid  = 1'b1;
        dbg_addr   = 5'd20;
        dbg_data   = 32'hD000_0014;
        for (int i = 0; i < 6; i++) begin
            if (win_tbl[i] == 1)
                push_write(1, dbg_addr, dbg_data, 1'b1);
            else
                push_write(0, core_addr, core_data, 1'b1);
            wait_accept();
            t3 = 1'b1;
            if (win_tbl[i] == 1) begin
                dbg_addr = 5'd21;
                dbg_data = 32'hD000_0015;
            end else begin
                ck++;
                core_addr = 5'(10 + ck);
                core_data = 32'hC000_0000 + 32'(ck);
            end
            if (i == 5) begin
                core_valid = 1'b0;
                dbg_valid  = 1'b0;
            end
            step();
            t3 = 1'b0;
        end

        // Reset while a write is held: dropped, never committed.
        core_valid = 1'b1;
        core_addr  = 5'd9;
        core_data  = 32'h0000_0099;
        push_write(0, 5'd9, 32'h0000_0099, 1'b0);
        wait_accept();
        core_valid = 1'b0;
        @(negedge clk);
        check("midhold_busy", 64'(busy), 64'd1);
        step();
        resetn = 1'b0;
        step();
        @(negedge clk);
        check("midhold_rst_we", 64'(rf_we), 64'd0);
        check("midhold_rst_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        t3 = 1'b1;
        step();
        t3 = 1'b0;
        step();

        // Debug write to register 0.
        dbg_valid = 1'b1;
        dbg_addr  = 5'd0;
        dbg_data  = 32'h0000_1234;
`ifdef REGARB_ZERO_GUARD_EN
        push_write(1, 5'd0, 32'h0000_1234, 1'b0);
`else
        push_write(1, 5'd0, 32'h0000_1234, 1'b1);
`endif
        wait_accept();
        dbg_valid = 1'b0;
        @(negedge clk);
        check("zero_busy", 64'(busy), 64'd1);
`ifdef REGARB_ZERO_GUARD_EN
        check("zero_we", 64'(rf_we), 64'd0);
`else
        check("zero_we", 64'(rf_we), 64'd1);
        check("zero_waddr", 64'(rf_waddr), 64'd0);
`endif
        step();
        t3 = 1'b1;
        step();
        t3 = 1'b0;
        @(negedge clk);
        check("zero_done_busy", 64'(busy), 64'd0);
        check("zero_done_we", 64'(rf_we), 64'd0);

        repeat (3) step();
        check("acc_queue_empty", 64'(acc_q.size()), 64'd0);
        check("commit_queue_empty", 64'(wa_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_wr_arb.md
# reg_wr_arb

Write-port arbiter and commit sequencer for the CPU general register file. It accepts register write requests from two requesters, the core writeback stage and the debug host. It selects one winner, holds that write stable, and presents it to the register file's single write port until the T3 phase strobe commits it. Core wins by default; a starvation counter guarantees debug progress.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- STARVE_MAX, 4, consecutive debug losses before debug is forced to win (1..15)

Ports:
- clk  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- t3  input  1  T3 phase strobe; the register file commits on the clk edge where t3=1 and rf_we=1
- core_valid  input  1  core write request
- core_addr  input  ADDR_W  core destination register
- core_data  input  DATA_W  core write data
- core_ready  output  1  one-cycle accept pulse for core request
- dbg_valid  input  1  debug write request
- dbg_addr  input  ADDR_W  debug destination register
- dbg_data  input  DATA_W  debug write data
- dbg_ready  output  1  one-cycle accept pulse for debug request
- rf_we  output  1  write enable to register file
- rf_waddr  output  ADDR_W  held write address
- rf_wdata  output  DATA_W  held write data
- busy  output  1  high while a write is held (state HOLD)

## Operation
- Two-state FSM: IDLE, HOLD. Reset state IDLE.
- IDLE, no valid: stay; all handshake outputs 0.
- IDLE, any valid: pick winner, latch its addr/data into the hold registers, pulse the winner's ready for exactly that cycle, next state HOLD.
- Winner rule: core if core_valid and starve_cnt != STARVE_MAX; otherwise debug if dbg_valid; otherwise core.
- starve_cnt (4 bits, reset 0): +1 when core wins while dbg_valid=1; cleared to 0 when debug wins; saturates at STARVE_MAX.
- HOLD: rf_we=1 (subject to Configuration), rf_waddr/rf_wdata = held values, both ready=0. If t3=1 then next state IDLE, else stay.
- Requesters hold valid/addr/data stable until their ready pulse; inputs are sampled only in IDLE.
- Reset mid-HOLD: held write dropped, no commit, FSM to IDLE, starve_cnt=0.

## Timing
- Reset values: core_ready=0, dbg_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0.
- Accept latency: ready pulses in the first IDLE cycle with valid high (combinational from valid and state).
- rf_we/rf_waddr/rf_wdata/busy registered; asserted from the cycle after accept.
- Commit occurs on the first clk edge in HOLD with t3=1; rf_we deasserts the following cycle.
- t3 high on the accept cycle is ignored; commit waits for the next t3.
- Minimum spacing between accepts: 2 cycles (accept, HOLD with t3, IDLE). With t3 every 4 cycles, throughput is one write per T-cycle.
- Simultaneous valids: one accept per IDLE cycle; the loser keeps valid and is reconsidered at the next IDLE.

## Configuration
- REGARB_ZERO_GUARD_EN defined: a request to address 0 is accepted and handshaken normally, passes through HOLD, and rf_we stays 0 for it. Register 0 is never written.
- Not defined: address 0 is written like any other register.

## Test plan
- Reset: assert resetn=0 with core_valid=1 for 2 cycles, then release -> all outputs 0 during reset; core_ready pulses in the first cycle after release.
- Single core write: core_addr=3, core_data=0xDEADBEEF; t3 two cycles after accept -> rf_we=1 with waddr=3, wdata=0xDEADBEEF held until the t3 edge; rf_we=0 the next cycle.
- Contention/starvation: STARVE_MAX=4, core_valid and dbg_valid held high continuously -> core wins 4 accepts, debug wins the 5th, core wins the 6th.
- t3 on the accept cycle: t3=1 in the same cycle as core_ready -> no commit then; commit at the next t3.
- Reset mid-HOLD: resetn=0 while busy=1 and before t3 -> rf_we=0 and busy=0 after the edge; no write observed at the register file.
- Zero guard: dbg_addr=0, dbg_data=0x1234 -> with REGARB_ZERO_GUARD_EN, dbg_ready pulses and busy=1 but rf_we stays 0; without the macro, rf_we=1 with waddr=0.
